// File: rtl/ff_bank_pkg.sv
// rtl/ff_bank_pkg.sv - shared types and constants for the ff_bank flip-flop bank
package ff_bank_pkg;

  // Flip-flop personality, shared by every channel of the bank.
  typedef enum logic [1:0] {
    FF_D  = 2'd0,
    FF_T  = 2'd1,
    FF_JK = 2'd2,
    FF_SR = 2'd3
  } ff_mode_e;

  // Resolution of the S=R=1 input in SR mode.
  localparam int SR_HOLD = 0;
  localparam int SR_SET  = 1;
  localparam int SR_RST  = 2;

  // True when a policy value is one the cell knows how to build.
  function automatic bit sr_policy_ok(input int policy);
    return (policy == SR_HOLD) || (policy == SR_SET) || (policy == SR_RST);
  endfunction

endpackage

// File: rtl/ff_cell.sv
// rtl/ff_cell.sv - one storage bit with selectable D/T/JK/SR behaviour
import ff_bank_pkg::*;

module ff_cell #(
  parameter int SR_POLICY = SR_HOLD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rst_val,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  output logic       q,
  output logic       conflict
);

  logic q_r;
  logic q_next;
  logic sr_both;

  // Value taken when S and R are both asserted; fixed at build time so the
  // forbidden input never produces an unknown.
  always_comb begin
    sr_both = q_r;
    if (SR_POLICY == SR_SET) begin
      sr_both = 1'b1;
    end else if (SR_POLICY == SR_RST) begin
      sr_both = 1'b0;
    end
  end

  // Next-state selection for the active personality; disabled cells hold.
  always_comb begin
    q_next = q_r;
    if (en) begin
      case (mode)
        FF_D:    q_next = a;
        FF_T:    q_next = q_r ^ a;
        FF_JK: begin
          case ({a, b})
            2'b00:   q_next = q_r;
            2'b01:   q_next = 1'b0;
            2'b10:   q_next = 1'b1;
            default: q_next = ~q_r;
          endcase
        end
        default: begin
          case ({a, b})
            2'b00:   q_next = q_r;
            2'b01:   q_next = 1'b0;
            2'b10:   q_next = 1'b1;
            default: q_next = sr_both;
          endcase
        end
      endcase
    end
  end

  // Conflict is only meaningful for an enabled SR cell with both inputs high.
  always_comb begin
    conflict = en & (mode == FF_SR) & a & b;
  end

  // State register with synchronous reset to the per-cell reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= rst_val;
    end else begin
      q_r <= q_next;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/ff_bank.sv
// rtl/ff_bank.sv - WIDTH-channel flip-flop bank with SR conflict reporting
import ff_bank_pkg::*;

module ff_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RST_VAL   = '0,
  parameter int               SR_POLICY = 0,
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] err_flag,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_pulse
);

  // Unsupported build parameters stop elaboration rather than build silently.
  if (!sr_policy_ok(SR_POLICY)) begin : g_bad_policy
    $error("ff_bank: SR_POLICY must be 0, 1 or 2");
  end
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("ff_bank: WIDTH must be in 1..64");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("ff_bank: CNT_W must be at least 1");
  end

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] q_int;
  logic [WIDTH-1:0] conflict;
  logic             any_conflict;
  logic [WIDTH-1:0] flag_r;
  logic [WIDTH-1:0] flag_next;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_next;
  logic             pulse_r;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(
      .SR_POLICY(SR_POLICY)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RST_VAL[i]),
      .en      (en),
      .mode    (mode),
      .a       (a[i]),
      .b       (b[i]),
      .q       (q_int[i]),
      .conflict(conflict[i])
    );
  end

  assign any_conflict = |conflict;

  // Sticky flags: clear first, then OR in this cycle's events so a conflict
  // coinciding with err_clr is still recorded.
  always_comb begin
    flag_next = (err_clr ? '0 : flag_r) | conflict;
  end

  // Counter counts conflict cycles (not conflicting channels) and saturates.
  always_comb begin
    cnt_base = err_clr ? '0 : cnt_r;
    cnt_next = cnt_base;
    if (any_conflict && (cnt_base != CNT_MAX)) begin
      cnt_next = cnt_base + CNT_ONE;
    end
  end

  // Error bookkeeping registers; reset beats any conflict in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_r  <= '0;
      cnt_r   <= '0;
      pulse_r <= 1'b0;
    end else begin
      flag_r  <= flag_next;
      cnt_r   <= cnt_next;
      pulse_r <= any_conflict;
    end
  end

  assign q         = q_int;
  assign q_bar     = ~q_int;
  assign err_flag  = flag_r;
  assign err_cnt   = cnt_r;
  assign err_pulse = pulse_r;

endmodule

// File: tb/tb_ff_bank.sv
// tb/tb_ff_bank.sv - directed self-checking bench for ff_bank
`timescale 1ns/1ps
import ff_bank_pkg::*;

module tb_ff_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [7:0] a;
  logic [7:0] b;
  logic       err_clr;

  logic [7:0] q0, qb0, f0;
  logic [7:0] c0;
  logic       p0;
  logic [7:0] q1, qb1, f1;
  logic [7:0] c1;
  logic       p1;
  logic [7:0] q2, qb2, f2;
  logic [7:0] c2;
  logic       p2;
  logic [7:0] qs, qbs, fs;
  logic [1:0] cs;
  logic       ps;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ff_bank #(.WIDTH(8), .RST_VAL(8'hA5), .SR_POLICY(0), .CNT_W(8)) u_hold (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
    .q(q0), .q_bar(qb0), .err_flag(f0), .err_cnt(c0), .err_pulse(p0));

  ff_bank #(.WIDTH(8), .RST_VAL(8'hA5), .SR_POLICY(1), .CNT_W(8)) u_set (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
    .q(q1), .q_bar(qb1), .err_flag(f1), .err_cnt(c1), .err_pulse(p1));

  ff_bank #(.WIDTH(8), .RST_VAL(8'hA5), .SR_POLICY(2), .CNT_W(8)) u_rst (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
    .q(q2), .q_bar(qb2), .err_flag(f2), .err_cnt(c2), .err_pulse(p2));

  ff_bank #(.WIDTH(8), .RST_VAL(8'hA5), .SR_POLICY(0), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
    .q(qs), .q_bar(qbs), .err_flag(fs), .err_cnt(cs), .err_pulse(ps));

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Apply the currently driven inputs for one rising edge, then settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] m,
                       input logic [7:0] av, input logic [7:0] bv, input logic c);
    rst = r; en = e; mode = m; a = av; b = bv; err_clr = c;
  endtask

  initial begin
    drive(1'b1, 1'b0, FF_D, 8'h00, 8'h00, 1'b0);
    step();
    check("rst_q", q0, 8'hA5);
    check("rst_q_bar", qb0, 8'h5A);
    check("rst_flag", f0, 8'h00);
    check("rst_cnt", c0, 8'h00);
    check("rst_pulse", p0, 1'b0);

    drive(1'b0, 1'b1, FF_D, 8'h00, 8'h00, 1'b0);
    step();
    check("d_zero", q0, 8'h00);
    drive(1'b0, 1'b1, FF_D, 8'h3C, 8'hFF, 1'b0);
    step();
    check("d_3c", q0, 8'h3C);
    check("d_3c_q_bar", qb0, 8'hC3);

    drive(1'b0, 1'b1, FF_T, 8'hFF, 8'h00, 1'b0);
    step();
    check("t_first", q0, 8'hC3);
    step();
    check("t_second", q0, 8'h3C);

    drive(1'b0, 1'b0, FF_T, 8'hFF, 8'h00, 1'b0);
    step();
    check("t_en0_a", q0, 8'h3C);
    step();
    check("t_en0_b", q0, 8'h3C);

    drive(1'b0, 1'b1, FF_D, 8'h0F, 8'h00, 1'b0);
    step();
    check("d_0f", q0, 8'h0F);
    drive(1'b0, 1'b1, FF_JK, 8'hF0, 8'h0F, 1'b0);
    step();
    check("jk_set_reset", q0, 8'hF0);
    drive(1'b0, 1'b1, FF_JK, 8'hFF, 8'hFF, 1'b0);
    step();
    check("jk_toggle", q0, 8'h0F);
    check("jk_no_pulse", p0, 1'b0);
    check("jk_no_flag", f0, 8'h00);
    drive(1'b0, 1'b1, FF_JK, 8'h00, 8'h00, 1'b0);
    step();
    check("jk_hold", q0, 8'h0F);

    drive(1'b0, 1'b1, FF_D, 8'h55, 8'h00, 1'b0);
    step();
    check("d_55", q0, 8'h55);
    drive(1'b0, 1'b1, FF_SR, 8'hFF, 8'hFF, 1'b0);
    step();
    check("sr_hold_q", q0, 8'h55);
    check("sr_set_q", q1, 8'hFF);
    check("sr_rst_q", q2, 8'h00);
    check("sr_hold_flag", f0, 8'hFF);
    check("sr_set_flag", f1, 8'hFF);
    check("sr_rst_flag", f2, 8'hFF);
    check("sr_hold_cnt", c0, 8'd1);
    check("sr_set_cnt", c1, 8'd1);
    check("sr_rst_cnt", c2, 8'd1);
    check("sr_hold_pulse", p0, 1'b1);
    check("sr_set_pulse", p1, 1'b1);
    check("sr_rst_pulse", p2, 1'b1);

    drive(1'b0, 1'b1, FF_SR, 8'h0F, 8'hF0, 1'b0);
    step();
    check("sr_plain_q", q0, 8'h0F);
    check("sr_pulse_drop", p0, 1'b0);
    check("sr_flag_sticky", f0, 8'hFF);
    check("sr_cnt_keep", c0, 8'd1);

    drive(1'b0, 1'b1, FF_SR, 8'h00, 8'h00, 1'b1);
    step();
    check("clr_flag", f0, 8'h00);
    check("clr_cnt", c0, 8'd0);
    check("clr_sat_cnt", cs, 2'd0);

    drive(1'b0, 1'b1, FF_SR, 8'hFF, 8'hFF, 1'b0);
    step();
    check("sat_cnt_1", cs, 2'd1);
    step();
    check("sat_cnt_2", cs, 2'd2);
    step();
    check("sat_cnt_3", cs, 2'd3);
    step();
    check("sat_cnt_4", cs, 2'd3);
    step();
    check("sat_cnt_5", cs, 2'd3);
    check("sat_pulse", ps, 1'b1);
    check("wide_cnt_5", c0, 8'd5);

    drive(1'b0, 1'b1, FF_SR, 8'h01, 8'h01, 1'b1);
    step();
    check("clr_conf_cnt", cs, 2'd1);
    check("clr_conf_flag", fs, 8'h01);
    check("clr_conf_wide_cnt", c0, 8'd1);
    check("clr_conf_pulse", p0, 1'b1);

    drive(1'b1, 1'b1, FF_SR, 8'hFF, 8'hFF, 1'b0);
    step();
    check("mid_rst_cnt", c0, 8'd0);
    check("mid_rst_flag", f0, 8'h00);
    check("mid_rst_pulse", p0, 1'b0);
    check("mid_rst_q_hold", q0, 8'hA5);
    check("mid_rst_q_set", q1, 8'hA5);
    check("mid_rst_q_rst", q2, 8'hA5);
    check("mid_rst_sat_cnt", cs, 2'd0);

    drive(1'b0, 1'b0, FF_SR, 8'hFF, 8'hFF, 1'b0);
    step();
    check("en0_sr_pulse", p0, 1'b0);
    check("en0_sr_cnt", c0, 8'd0);
    check("en0_sr_flag", f0, 8'h00);
    check("en0_sr_q", q1, 8'hA5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
